// File: rtl/pool_output_packer_if.sv
// Write port from the pool output packer to activation memory.
// Carries a word-aligned byte address, 32-bit data and byte enables, with a valid/ready handshake.
interface pool_output_packer_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;

  modport master (output mem_valid, output mem_addr, output mem_wdata, output mem_be, input mem_ready);
  modport slave  (input mem_valid, input mem_addr, input mem_wdata, input mem_be, output mem_ready);
endinterface

// File: rtl/pool_output_packer.sv
// Packs the max-pool unit's one-byte-per-cycle output into byte-enabled 32-bit words.
// Words are queued in a small FIFO and written to activation memory; the input is never stalled.
module pool_output_packer #(
  parameter int unsigned MAX_N      = 512,
  parameter int unsigned N_BITS     = $clog2(MAX_N + 1),
  parameter int unsigned FILTER_H   = 2,
  parameter int unsigned FILTER_W   = 2,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [N_BITS-1:0] cfg_out_w,
  input  logic              in_valid,
  input  logic [N_BITS-1:0] in_row,
  input  logic [N_BITS-1:0] in_col,
  input  logic [7:0]        in_data,
  input  logic              flush,
  pool_output_packer_if.master mem,
  output logic              idle,
  output logic              overflow
);

  localparam int unsigned ROW_SH = $clog2(FILTER_H);
  localparam int unsigned COL_SH = $clog2(FILTER_W);
  localparam int unsigned WORD_W = ADDR_W - 2;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic [31:0]       data;
    logic [3:0]        be;
  } word_t;

  // Sample address; truncating operands to ADDR_W gives the same result modulo 2^ADDR_W.
  logic [N_BITS-1:0] row_blk, col_blk;
  logic [ADDR_W-1:0] samp_addr;
  logic [WORD_W-1:0] samp_word;
  logic [1:0]        samp_lane;

  assign row_blk   = in_row >> ROW_SH;
  assign col_blk   = in_col >> COL_SH;
  assign samp_addr = cfg_base_addr + ADDR_W'(row_blk) * ADDR_W'(cfg_out_w) + ADDR_W'(col_blk);
  assign samp_word = samp_addr[ADDR_W-1:2];
  assign samp_lane = samp_addr[1:0];

  logic              pend_valid, pend_valid_n;
  logic [WORD_W-1:0] pend_word, pend_word_n;
  logic [31:0]       pend_data, pend_data_n;
  logic [3:0]        pend_be, pend_be_n;
  logic              flush_req, flush_req_n;
  logic              compat, evict;

  // Merge/evict/load decision for the pending word.
  always_comb begin
    compat       = pend_valid && (samp_word == pend_word) && !pend_be[samp_lane] && (pend_be != 4'hF);
    evict        = pend_valid && ((pend_be == 4'hF) || (in_valid && !compat) || (flush_req && !in_valid));
    pend_valid_n = pend_valid;
    pend_word_n  = pend_word;
    pend_data_n  = pend_data;
    pend_be_n    = pend_be;
    flush_req_n  = flush_req;

    if (in_valid) begin
      if (!compat) begin
        pend_valid_n = 1'b1;
        pend_word_n  = samp_word;
        pend_data_n  = '0;
        pend_be_n    = '0;
      end
      for (int k = 0; k < 4; k++) begin
        if (samp_lane == 2'(k)) begin
          pend_data_n[8*k +: 8] = in_data;
          pend_be_n[k]          = 1'b1;
        end
      end
    end else if (evict) begin
      pend_valid_n = 1'b0;
      pend_be_n    = '0;
    end

    if (flush) begin
      flush_req_n = 1'b1;
    end else if (!in_valid && (!pend_valid || evict)) begin
      flush_req_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid <= 1'b0;
      pend_word  <= '0;
      pend_data  <= '0;
      pend_be    <= '0;
      flush_req  <= 1'b0;
    end else begin
      pend_valid <= pend_valid_n;
      pend_word  <= pend_word_n;
      pend_data  <= pend_data_n;
      pend_be    <= pend_be_n;
      flush_req  <= flush_req_n;
    end
  end

  // Word FIFO; pointers carry one extra wrap bit to tell full from empty.
  word_t            fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full, pop, do_write;
  word_t            head;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop        = !fifo_empty && mem.mem_ready;
  assign do_write   = evict && (!fifo_full || pop);
  assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (do_write) begin
      fifo_mem[wr_ptr[PTR_W-1:0]] <= '{word: pend_word, data: pend_data, be: pend_be};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)      rd_ptr <= rd_ptr + PTR_ONE;
      if (evict && !do_write) overflow <= 1'b1;
    end
  end

  assign mem.mem_valid = !fifo_empty;
  assign mem.mem_addr  = fifo_empty ? '0 : {head.word, 2'b00};
  assign mem.mem_wdata = fifo_empty ? '0 : head.data;
  assign mem.mem_be    = fifo_empty ? '0 : head.be;
  assign idle          = !pend_valid && fifo_empty && !flush_req;

endmodule
